// File: rtl/operand_fetch.sv
// Operand fetch: 32x32 register file, busy scoreboard and
// stage-1 read FSM with write-back bypass.
module operand_fetch #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [2:0]        stage,
    input  logic              rdReq,
    input  logic [5:0]        rsAddr,
    input  logic [5:0]        rtAddr,
    input  logic              destValid,
    input  logic [5:0]        destAddr,
    input  logic              regWrite,
    input  logic [5:0]        wbAddr,
    input  logic [DATA_W-1:0] wbValue,
    output logic [DATA_W-1:0] rsData,
    output logic [DATA_W-1:0] rtData,
    output logic              rdValid,
    output logic              stall
);

    localparam int AW = $clog2(NREGS);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] STALL = 1'b1;

    logic [0:0]        state;
    logic [AW-1:0]     latRs;
    logic [AW-1:0]     latRt;
    logic [AW-1:0]     latDest;
    logic              latDestValid;

    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  busy;

    logic [AW-1:0]     wbIdx;
    logic              wbHit;
    logic [AW-1:0]     selRs;
    logic [AW-1:0]     selRt;
    logic [AW-1:0]     selDest;
    logic              selDestValid;
    logic              rsBusy;
    logic              rtBusy;
    logic              destBusy;
    logic              hazard;
    logic              accept;
    logic              issue;
    logic              goStall;
    logic [DATA_W-1:0] rsVal;
    logic [DATA_W-1:0] rtVal;
    logic              unusedBits;

    assign unusedBits = ^{rsAddr[5], rtAddr[5], destAddr[5], wbAddr[5]};

    assign wbIdx = wbAddr[AW-1:0];
    assign wbHit = (stage == 3'd4) && regWrite && (wbIdx != '0);
    assign stall = (state == STALL);

    // Pick live or latched request, resolve hazard and bypassed operands
    always_comb begin
        selRs        = rsAddr[AW-1:0];
        selRt        = rtAddr[AW-1:0];
        selDest      = destAddr[AW-1:0];
        selDestValid = destValid;
        if (state == STALL) begin
            selRs        = latRs;
            selRt        = latRt;
            selDest      = latDest;
            selDestValid = latDestValid;
        end

        rsBusy   = busy[selRs] && !(wbHit && (selRs == wbIdx));
        rtBusy   = busy[selRt] && !(wbHit && (selRt == wbIdx));
        destBusy = busy[selDest] && !(wbHit && (selDest == wbIdx));
        hazard   = rsBusy || rtBusy || (selDestValid && destBusy);

        if (selRs == '0)
            rsVal = '0;
        else if (wbHit && (selRs == wbIdx))
            rsVal = wbValue;
        else
            rsVal = regs[selRs];

        if (selRt == '0)
            rtVal = '0;
        else if (wbHit && (selRt == wbIdx))
            rtVal = wbValue;
        else
            rtVal = regs[selRt];

        // A fresh request is not taken on the cycle after an issue so
        // rdValid can never stay high two cycles running.
        accept  = (state == IDLE) && (stage == 3'd1) && rdReq && !rdValid;
        issue   = (accept && !hazard) || ((state == STALL) && !hazard);
        goStall = accept && hazard;
    end

    // Register file write port; r0 is never written
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (wbHit) begin
            regs[wbIdx] <= wbValue;
        end
    end

    // Busy scoreboard: write-back clears, issue sets, set wins
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            busy <= '0;
        end else begin
            if (wbHit)
                busy[wbIdx] <= 1'b0;
            if (issue && selDestValid && (selDest != '0))
                busy[selDest] <= 1'b1;
        end
    end

    // Request FSM and latch of a held request
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            latRs        <= '0;
            latRt        <= '0;
            latDest      <= '0;
            latDestValid <= 1'b0;
        end else begin
            if (goStall) begin
                state        <= STALL;
                latRs        <= rsAddr[AW-1:0];
                latRt        <= rtAddr[AW-1:0];
                latDest      <= destAddr[AW-1:0];
                latDestValid <= destValid;
            end else if (issue) begin
                state <= IDLE;
            end
        end
    end

    // Operand registers and one-cycle valid pulse
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rsData  <= '0;
            rtData  <= '0;
            rdValid <= 1'b0;
        end else begin
            rdValid <= issue;
            if (issue) begin
                rsData <= rsVal;
                rtData <= rtVal;
            end
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: reads, stalls, bypass,
// WAW hold and reset during a stall.
module tb_operand_fetch;

    logic        clock = 1'b0;
    logic        resetn;
    logic [2:0]  stage;
    logic        rdReq;
    logic [5:0]  rsAddr;
    logic [5:0]  rtAddr;
    logic        destValid;
    logic [5:0]  destAddr;
    logic        regWrite;
    logic [5:0]  wbAddr;
    logic [31:0] wbValue;
    logic [31:0] rsData;
    logic [31:0] rtData;
    logic        rdValid;
    logic        stall;

    int vectors = 0;
    int miscompares = 0;
    logic [63:0] sb[$];
    logic prevValid = 1'b0;

    operand_fetch #(.DATA_W(32), .NREGS(32)) dut (
        .clock(clock), .resetn(resetn), .stage(stage), .rdReq(rdReq),
        .rsAddr(rsAddr), .rtAddr(rtAddr), .destValid(destValid),
        .destAddr(destAddr), .regWrite(regWrite), .wbAddr(wbAddr),
        .wbValue(wbValue), .rsData(rsData), .rtData(rtData),
        .rdValid(rdValid), .stall(stall)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard: every rdValid pulse consumes one expected pair
    always @(negedge clock) begin
        if (rdValid === 1'b1) begin
            check("rdValid_back_to_back", {31'd0, prevValid}, 32'd0);
            check("sb_has_entry", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                logic [63:0] e;
                e = sb.pop_front();
                check("rsData", rsData, e[63:32]);
                check("rtData", rtData, e[31:0]);
            end
        end
        prevValid <= rdValid;
    end

    task automatic idle();
        stage = 3'd0;
        rdReq = 1'b0;
        destValid = 1'b0;
        regWrite = 1'b0;
    endtask

    task automatic wb(input logic [5:0] a, input logic [31:0] v);
        stage = 3'd4;
        regWrite = 1'b1;
        wbAddr = a;
        wbValue = v;
        @(negedge clock);
        idle();
    endtask

    task automatic post(input logic [5:0] rs, input logic [5:0] rt,
                        input logic dv, input logic [5:0] dst,
                        input logic [31:0] ers, input logic [31:0] ert);
        stage = 3'd1;
        rdReq = 1'b1;
        rsAddr = rs;
        rtAddr = rt;
        destValid = dv;
        destAddr = dst;
        sb.push_back({ers, ert});
    endtask

    task automatic read_now(input logic [5:0] rs, input logic [5:0] rt,
                            input logic dv, input logic [5:0] dst,
                            input logic [31:0] ers, input logic [31:0] ert);
        post(rs, rt, dv, dst, ers, ert);
        @(negedge clock);
        check("issue_valid", {31'd0, rdValid}, 32'd1);
        check("issue_stall", {31'd0, stall}, 32'd0);
        idle();
        @(negedge clock);
        check("pulse_end", {31'd0, rdValid}, 32'd0);
    endtask

    task automatic stalled(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (i == 0) idle();
            check("stall_high", {31'd0, stall}, 32'd1);
            check("stall_novalid", {31'd0, rdValid}, 32'd0);
        end
    endtask

    task automatic wb_release(input logic [5:0] a, input logic [31:0] v);
        stage = 3'd4;
        regWrite = 1'b1;
        wbAddr = a;
        wbValue = v;
        @(negedge clock);
        check("release_stall", {31'd0, stall}, 32'd0);
        check("release_valid", {31'd0, rdValid}, 32'd1);
        idle();
        @(negedge clock);
        check("release_pulse", {31'd0, rdValid}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        idle();
        rsAddr = '0; rtAddr = '0; destAddr = '0;
        wbAddr = '0; wbValue = '0;
        repeat (2) @(negedge clock);
        check("rst_rsData", rsData, 32'd0);
        check("rst_rtData", rtData, 32'd0);
        check("rst_rdValid", {31'd0, rdValid}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        resetn = 1'b1;
        @(negedge clock);

        // Plain write then read
        wb(6'd5, 32'h12345678);
        read_now(6'd5, 6'd0, 1'b0, 6'd0, 32'h12345678, 32'h0);

        // r0: ignores writes, never busy
        wb(6'd0, 32'hFFFFFFFF);
        read_now(6'd0, 6'd0, 1'b1, 6'd0, 32'h0, 32'h0);
        read_now(6'd0, 6'd0, 1'b0, 6'd0, 32'h0, 32'h0);

        // RAW on r7: three stall cycles, write-back releases via bypass
        read_now(6'd1, 6'd2, 1'b1, 6'd7, 32'h0, 32'h0);
        post(6'd7, 6'd0, 1'b0, 6'd0, 32'h0000CAFE, 32'h0);
        stalled(3);
        wb_release(6'd7, 32'h0000CAFE);

        // Same-edge bypass beats the stale r9 value; bit 5 ignored
        wb(6'd9, 32'h00001111);
        read_now(6'd0, 6'd0, 1'b1, 6'd9, 32'h0, 32'h0);
        post(6'd41, 6'd5, 1'b0, 6'd0, 32'h0000A5A5, 32'h12345678);
        stalled(1);
        wb_release(6'd9, 32'h0000A5A5);
        read_now(6'd9, 6'd9, 1'b0, 6'd0, 32'h0000A5A5, 32'h0000A5A5);

        // WAW on r3: held, then r3 busy again after issue
        read_now(6'd0, 6'd0, 1'b1, 6'd3, 32'h0, 32'h0);
        post(6'd1, 6'd2, 1'b1, 6'd3, 32'h0, 32'h0);
        stalled(2);
        wb_release(6'd3, 32'h00000033);
        post(6'd3, 6'd0, 1'b0, 6'd0, 32'h00000044, 32'h0);
        stalled(1);
        wb_release(6'd3, 32'h00000044);

        // Reset during a stall discards the request
        read_now(6'd0, 6'd0, 1'b1, 6'd4, 32'h0, 32'h0);
        stage = 3'd1;
        rdReq = 1'b1;
        rsAddr = 6'd4;
        rtAddr = 6'd0;
        destValid = 1'b0;
        @(negedge clock);
        idle();
        check("pre_rst_stall", {31'd0, stall}, 32'd1);
        resetn = 1'b0;
        #1;
        check("mid_rst_stall", {31'd0, stall}, 32'd0);
        check("mid_rst_rdValid", {31'd0, rdValid}, 32'd0);
        check("mid_rst_rsData", rsData, 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        repeat (2) @(negedge clock);
        read_now(6'd5, 6'd9, 1'b0, 6'd0, 32'h0, 32'h0);
        read_now(6'd4, 6'd7, 1'b0, 6'd0, 32'h0, 32'h0);
        read_now(6'd3, 6'd3, 1'b0, 6'd0, 32'h0, 32'h0);

        repeat (2) @(negedge clock);
        check("sb_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
